onehot_splitter: RTL and testbench



---
 rtl/onehot_splitter.sv | 90 +++++++++
 tb/tb_onehot_splitter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_splitter.sv
// Splits a captured word into one-hot words, lowest set bit first, one per output handshake.
// Define ONEHOT_SPLITTER_SEQ_EN to add out_seq, the ordinal of each word within its input word.
module onehot_splitter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_last,
`ifdef ONEHOT_SPLITTER_SEQ_EN
  output logic [$clog2(WIDTH)-1:0] out_seq,
`endif
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_less;
  logic [WIDTH-1:0] mask_rest;
  logic             is_last;

`ifdef ONEHOT_SPLITTER_SEQ_EN
  localparam int SEQW = $clog2(WIDTH);
  logic [SEQW-1:0] seq;
  assign out_seq = seq;
`endif

  // mask - 1 is only meaningful for a nonzero mask, which EMIT guarantees.
  assign mask_less = (mask != '0) ? (mask - WIDTH'(1)) : '0;
  assign mask_rest = mask & mask_less;
  assign is_last   = (mask_rest == '0);

  assign in_ready   = (state == IDLE) & ~rst;
  assign out_valid  = (state == EMIT);
  assign busy       = (state == EMIT);
  assign out_onehot = (state == EMIT) ? (mask & (~mask + WIDTH'(1))) : '0;
  assign out_last   = (state == EMIT) & is_last;

  // A zero word is accepted and dropped; the last handshake clears mask to zero on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
`ifdef ONEHOT_SPLITTER_SEQ_EN
      seq   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_data != '0) begin
              mask  <= in_data;
              state <= EMIT;
            end
`ifdef ONEHOT_SPLITTER_SEQ_EN
            seq <= '0;
`endif
          end
        end
        EMIT: begin
          if (out_ready) begin
            mask <= mask_rest;
            if (is_last) begin
              state <= IDLE;
            end else begin
`ifdef ONEHOT_SPLITTER_SEQ_EN
              seq <= seq + SEQW'(1);
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          mask  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_splitter.sv
// Directed-vector bench for onehot_splitter at WIDTH=8 with hand-computed expectations.
// Exercises out_seq as well when ONEHOT_SPLITTER_SEQ_EN is defined.
module tb_onehot_splitter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic       out_last;
  logic       busy;
`ifdef ONEHOT_SPLITTER_SEQ_EN
  logic [2:0] out_seq;
`endif

  int vectors;
  int miscompares;

  onehot_splitter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .out_last  (out_last),
`ifdef ONEHOT_SPLITTER_SEQ_EN
    .out_seq   (out_seq),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Expected one-hot sequences for the out_ready-high words.
  logic [7:0] exp26 [3] = '{8'h02, 8'h04, 8'h20};
  logic [3:0] stall_pat = 4'b1001;

  initial begin
    int idx;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset state
    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_onehot", 32'(out_onehot), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Word 0x26 with out_ready held high
    applyStimulus(1'b1, 8'h26, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("w26_valid", 32'(out_valid), 32'd1);
      checkOutput("w26_onehot", 32'(out_onehot), 32'(exp26[i]));
      checkOutput("w26_last", 32'(out_last), (i == 2) ? 32'd1 : 32'd0);
      checkOutput("w26_ready", 32'(in_ready), 32'd0);
      checkOutput("w26_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    checkOutput("w26_done_ready", 32'(in_ready), 32'd1);
    checkOutput("w26_done_valid", 32'(out_valid), 32'd0);

    // Zero word is dropped, then MSB-only word
    applyStimulus(1'b1, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("zero_valid", 32'(out_valid), 32'd0);
    checkOutput("zero_ready", 32'(in_ready), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    in_data = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("msb_valid", 32'(out_valid), 32'd1);
    checkOutput("msb_onehot", 32'(out_onehot), 32'h80);
    checkOutput("msb_last", 32'(out_last), 32'd1);
    @(negedge clk);
    checkOutput("msb_done_valid", 32'(out_valid), 32'd0);

    // 0xFF under backpressure pattern 1,0,0,1,...
    applyStimulus(1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      checkOutput("ff_valid", 32'(out_valid), 32'd1);
      checkOutput("ff_onehot", 32'(out_onehot), 32'(8'h01 << idx));
      checkOutput("ff_last", 32'(out_last), (idx == 7) ? 32'd1 : 32'd0);
      out_ready = stall_pat[3 - (cyc % 4)];
      if (out_ready) idx++;
      @(negedge clk);
    end
    checkOutput("ff_count", 32'(idx), 32'd8);
    checkOutput("ff_done_valid", 32'(out_valid), 32'd0);
    checkOutput("ff_done_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of emitting 0xAA
    applyStimulus(1'b1, 8'hAA, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("aa_first", 32'(out_onehot), 32'h02);
    @(negedge clk);
    checkOutput("aa_second", 32'(out_onehot), 32'h08);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("aa_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("aa_rst_onehot", 32'(out_onehot), 32'd0);
    checkOutput("aa_rst_busy", 32'(busy), 32'd0);
    checkOutput("aa_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("aa_post_valid", 32'(out_valid), 32'd0);
      checkOutput("aa_post_ready", 32'(in_ready), 32'd1);
      checkOutput("aa_post_busy", 32'(busy), 32'd0);
    end

`ifdef ONEHOT_SPLITTER_SEQ_EN
    // Ordinal tracking on 0x91, then restart on 0x06
    begin
      logic [7:0] exp91 [3] = '{8'h01, 8'h10, 8'h80};
      logic [7:0] exp06 [2] = '{8'h02, 8'h04};
      applyStimulus(1'b1, 8'h91, 1'b1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("s91_onehot", 32'(out_onehot), 32'(exp91[i]));
        checkOutput("s91_seq", 32'(out_seq), 32'(i));
        checkOutput("s91_last", 32'(out_last), (i == 2) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      applyStimulus(1'b1, 8'h06, 1'b1);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("s06_onehot", 32'(out_onehot), 32'(exp06[i]));
        checkOutput("s06_seq", 32'(out_seq), 32'(i));
      end
      @(negedge clk);
      checkOutput("s06_done_valid", 32'(out_valid), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
